// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- control/status bundle between the PC sequencer and its
// environment (instruction memory, decoder, address generator).
//   master : drives Start, Mem_ready, Op, Cond, PC_in; observes sequencer outputs
//   slave  : the sequencer itself
interface pc_sequencer_if;
   logic        Start;
   logic        Mem_ready;
   logic [2:0]  Op;
   logic        Cond;
   logic [31:0] PC_in;
   logic        Mem_req;
   logic        IR_load;
   logic        PC_enable;
   logic [1:0]  PC_select;
   logic        INC_select;
   logic [31:0] RA;
   logic        Halted;
   logic        Stack_ovf;
   logic        Stack_unf;

   modport master (
      output Start, Mem_ready, Op, Cond, PC_in,
      input  Mem_req, IR_load, PC_enable, PC_select, INC_select, RA,
             Halted, Stack_ovf, Stack_unf
   );

   modport slave (
      input  Start, Mem_ready, Op, Cond, PC_in,
      output Mem_req, IR_load, PC_enable, PC_select, INC_select, RA,
             Halted, Stack_ovf, Stack_unf
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- instruction sequencing FSM with a return-address stack.
// Walks IDLE -> FETCH -> DECODE -> EXECUTE -> FETCH ..., issuing fetch
// requests, IR loads and a single PC update strobe per instruction.
// CALL pushes PC_in+1, RET pops; stack overflow/underflow and the HALT op
// park the sequencer in HALT until Reset.
// Ports:
//   Clock  : clock, all state on rising edge
//   Reset  : asynchronous, active-high
//   bus    : pc_sequencer_if.slave (Start/Mem_ready/Op/Cond/PC_in in,
//            Mem_req/IR_load/PC_enable/PC_select/INC_select/RA/status out)
module pc_sequencer #(
   parameter int unsigned STACK_DEPTH = 4
) (
   input logic            Clock,
   input logic            Reset,
   pc_sequencer_if.slave  bus
);

   localparam int unsigned SPW  = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDXW = $clog2(STACK_DEPTH);
   localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_DECODE  = 3'd2;
   localparam logic [2:0] S_EXECUTE = 3'd3;
   localparam logic [2:0] S_HALT    = 3'd4;

   localparam logic [2:0] OP_BRANCH = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_CALL   = 3'b011;
   localparam logic [2:0] OP_RET    = 3'b100;
   localparam logic [2:0] OP_HALT   = 3'b111;

   localparam logic [1:0] SEL_RA  = 2'b00;
   localparam logic [1:0] SEL_INC = 2'b01;
   localparam logic [1:0] SEL_ABS = 2'b10;

   logic [2:0]      state, state_nxt;
   logic [2:0]      op_q;
   logic            cond_q;
   logic [SPW-1:0]  sp;
   logic [31:0]     stack [STACK_DEPTH];
   logic            ovf_q, unf_q;
   logic            push, pop, set_ovf, set_unf;
   logic [IDXW-1:0] top_idx, push_idx;

   // sp never exceeds STACK_DEPTH, so the low bits address the slot directly
   assign top_idx  = IDXW'(sp - 1'b1);
   assign push_idx = IDXW'(sp);

   assign bus.RA        = (sp != '0) ? stack[top_idx] : '0;
   assign bus.Halted    = (state == S_HALT);
   assign bus.Stack_ovf = ovf_q;
   assign bus.Stack_unf = unf_q;

   always_comb begin
      state_nxt      = state;
      bus.Mem_req    = 1'b0;
      bus.IR_load    = 1'b0;
      bus.PC_enable  = 1'b0;
      bus.PC_select  = SEL_INC;
      bus.INC_select = 1'b0;
      push           = 1'b0;
      pop            = 1'b0;
      set_ovf        = 1'b0;
      set_unf        = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.Start) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            bus.Mem_req = 1'b1;
            bus.IR_load = bus.Mem_ready;
            if (bus.Mem_ready) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            state_nxt = S_EXECUTE;
         end
         S_EXECUTE: begin
            state_nxt = S_FETCH;
            case (op_q)
               OP_BRANCH: begin
                  bus.PC_enable  = 1'b1;
                  bus.INC_select = cond_q;
               end
               OP_JUMP: begin
                  bus.PC_enable = 1'b1;
                  bus.PC_select = SEL_ABS;
               end
               OP_CALL: begin
                  if (sp == SP_FULL) begin
                     set_ovf   = 1'b1;
                     state_nxt = S_HALT;
                  end else begin
                     bus.PC_enable = 1'b1;
                     bus.PC_select = SEL_ABS;
                     push          = 1'b1;
                  end
               end
               OP_RET: begin
                  if (sp == '0) begin
                     set_unf   = 1'b1;
                     state_nxt = S_HALT;
                  end else begin
                     bus.PC_enable = 1'b1;
                     bus.PC_select = SEL_RA;
                     pop           = 1'b1;
                  end
               end
               OP_HALT: begin
                  state_nxt = S_HALT;
               end
               default: begin
                  // ALU/NOP and the reserved encodings step by one
                  bus.PC_enable = 1'b1;
               end
            endcase
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state  <= S_IDLE;
         op_q   <= '0;
         cond_q <= 1'b0;
         sp     <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         for (int unsigned i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_DECODE) begin
            op_q   <= bus.Op;
            cond_q <= bus.Cond;
         end
         if (push) begin
            stack[push_idx] <= bus.PC_in + 32'd1;
            sp              <= sp + 1'b1;
         end
         if (pop) sp <= sp - 1'b1;
         if (set_ovf) ovf_q <= 1'b1;
         if (set_unf) unf_q <= 1'b1;
      end
   end

endmodule
